muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised multi-cycle RV32M/RV64M multiply/divide execute unit. Sits beside the ALU in the Execute stage of the 5-stage pipeline.
- Accepts one M-extension operation per request and holds the pipeline through a stall request to the hazard unit.
- Returns the result together with the destination register tag on a one-cycle done pulse, which the EX/MEM register captures.
- Supports abort on flush and a selectable single-cycle or iterative multiplier.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- FAST_MUL, 0, 1 = single-cycle multiply path; 0 = iterative shift-add multiply taking XLEN cycles.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  EX holds a valid M-extension instruction.
- flush_i  in  1  FlushE from the hazard unit; cancels the request or the operation in flight.
- funct3_i  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a_i  in  XLEN  forwarded rs1 operand (SrcA).
- b_i  in  XLEN  forwarded rs2 operand.
- rd_i  in  5  destination register tag.
- stall_o  out  1  hold PC, IF/ID and EX registers.
- busy_o  out  1  FSM is not in IDLE.
- done_o  out  1  result valid this cycle (one-cycle pulse).
- result_o  out  XLEN  operation result.
- rd_o  out  5  tag of the completed operation.

Behaviour:
- Reset (sync, active-high): state=IDLE, counter=0, all internal registers=0, stall_o=0, busy_o=0, done_o=0, result_o=0, rd_o=0. Reset mid-operation abandons the operation; no done pulse follows.
- States: IDLE, CALC, DONE.
- IDLE:
  - Acceptance = start_i & ~flush_i.
  - stall_o = acceptance, combinationally, in the same cycle.
  - On acceptance, latch funct3, rd, and the absolute values and sign flags of the operands. Signedness: MULH uses a and b signed; MULHSU uses a signed, b unsigned; DIV/REM signed; all others unsigned.
  - Next state is DONE for a special case or when FAST_MUL=1 with a mul op; otherwise CALC with counter=XLEN.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply, restoring subtract-shift for divide.
  - Counter decrements each cycle; at counter==1 the next state is DONE.
  - stall_o=1, busy_o=1.
- DONE:
  - done_o=1; result_o and rd_o valid; stall_o=0 so EX advances this cycle.
  - Next state is IDLE unconditionally. The new EX occupant is evaluated in IDLE next cycle, so there is no re-acceptance of the same instruction.
- Latency from the acceptance cycle T:
  - Iterative: done at T+XLEN+1.
  - FAST_MUL mul: done at T+1.
  - Special-case div: done at T+1.
- Result formation:
  - MUL returns the low XLEN bits of the 2*XLEN product.
  - MULH/MULHSU/MULHU return the high XLEN bits.
  - The product is negated if the operand signs differ (signed ops only).
  - The quotient is negated if the signs differ.
  - The remainder takes the dividend's sign.
- Special cases (DONE at T+1, no CALC):
  - Divide by zero: quotient = all ones; remainder = a_i.
  - Signed overflow (a = most-negative, b = -1): quotient = most-negative; remainder = 0.
- flush_i:
  - In IDLE, flush_i blocks acceptance.
  - In CALC, flush_i forces IDLE next cycle with no done pulse; stall_o drops in that same cycle.
  - In DONE, done_o still asserts; the hazard unit discards the result by flushing EX.
- start_i while busy_o=1 is ignored; operands are held internally, so changes on a_i/b_i are irrelevant.
- result_o and rd_o hold their last value outside DONE; consumers qualify them with done_o.

Decomposition:
- Shared package (riscv_pkg), constants only:
  - M-extension funct3 codes.
  - FSM state encoding (2-bit: IDLE=0, CALC=1, DONE=2).
  - The M-extension opcode/funct7 (0000001) for the decoder.
- One natural sub-module, muldiv_core_step: combinational single radix-2 iteration for both multiply and divide, instantiated once.

Test Plan:
- XLEN=32, FAST_MUL=0, DIVU a=100, b=7, rd=5 → stall_o high for cycles T..T+32; done_o at T+33 with result_o=14, rd_o=5; stall_o=0 in the done cycle.
- REM a=-7 (0xFFFFFFF9), b=2 → result_o=0xFFFFFFFF (-1); DIV with the same operands → 0xFFFFFFFD (-3).
- DIV a=0x80000000, b=0xFFFFFFFF → done at T+1, result 0x80000000. DIVU b=0 → 0xFFFFFFFF. REMU a=9, b=0 → 9.
- MULH a=0xFFFFFFFF (-1), b=0xFFFFFFFF → 0x00000000. MULHU with the same operands → 0xFFFFFFFE. MUL 6×7 → 42. Repeat with FAST_MUL=1: done at T+1.
- Start DIVU, then assert flush_i at T+10 → no done_o ever; busy_o=0 at T+11; a new MUL accepted at T+12 completes correctly.
- Assert reset at T+5 of a DIV → all outputs 0 next cycle; no done pulse; state IDLE.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32M/RV64M constants: M-extension funct3 codes, decoder opcode/funct7,
// and the multiply/divide FSM state encoding.
package riscv_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_32  = 7'b0111011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_core_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply or
// restoring subtract-shift divide, selected by is_div_i.
module muldiv_core_step
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] m_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rs;
    logic [XLEN-1:0] diff;
    logic            ge;

    always_comb begin
        sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
        rs   = {hi_i, lo_i[XLEN-1]};
        ge   = (rs >= {1'b0, m_i});
        // When ge holds the true difference is below m_i, so XLEN bits suffice.
        diff = rs[XLEN-1:0] - m_i;
        if (is_div_i) begin
            hi_o = ge ? diff : rs[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], ge};
        end else begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle M-extension execute unit: operands are reduced to magnitudes on
// acceptance, iterated in CALC, and sign-corrected on the way into DONE.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int FAST_MUL = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [4:0]      rd_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic [4:0]      rd_out_q, rd_out_d;
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] m_q, m_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            accept, is_div_in, sign_a_in, sign_b_in, a_neg_in, b_neg_in;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a_abs, b_abs, special_res, step_hi, step_lo;
    logic [2*XLEN-1:0] prod_fast;

    function automatic logic [XLEN-1:0] form_result(
        input logic [2:0]      op,
        input logic [XLEN-1:0] hi,
        input logic [XLEN-1:0] lo,
        input logic            a_neg,
        input logic            b_neg
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = (a_neg ^ b_neg) ? -{hi, lo} : {hi, lo};
        quo  = (a_neg ^ b_neg) ? -lo : lo;
        rem  = a_neg ? -hi : hi;
        case (op)
            F3_MUL:                        form_result = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  form_result = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               form_result = quo;
            default:                       form_result = rem;
        endcase
    endfunction

    always_comb begin
        is_div_in   = funct3_i[2];
        sign_a_in   = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                      (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
        sign_b_in   = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
        a_neg_in    = sign_a_in & a_i[XLEN-1];
        b_neg_in    = sign_b_in & b_i[XLEN-1];
        a_abs       = a_neg_in ? -a_i : a_i;
        b_abs       = b_neg_in ? -b_i : b_i;
        div_zero    = is_div_in & (b_i == '0);
        div_ovf     = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &
                      (a_i == MOST_NEG) & (b_i == '1);
        special_res = funct3_i[1] ? (div_zero ? a_i : '0) : (div_zero ? '1 : MOST_NEG);
    end

    if (FAST_MUL != 0) begin : g_fast_mul
        assign prod_fast = a_abs * b_abs;
    end else begin : g_iter_mul
        assign prod_fast = '0;
    end

    muldiv_core_step #(.XLEN(XLEN)) u_step (
        .is_div_i (op_q[2]),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .m_i      (m_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    assign accept = (state_q == ST_IDLE) & start_i & ~flush_i;

    always_comb begin
        // NOTE: every next-state value defaults to its register so no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rd_out_d = rd_out_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        m_d      = m_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = funct3_i;
                    rd_d    = rd_i;
                    a_neg_d = a_neg_in;
                    b_neg_d = b_neg_in;
                    hi_d    = '0;
                    lo_d    = a_abs;
                    m_d     = b_abs;
                    if (div_zero || div_ovf) begin
                        state_d  = ST_DONE;
                        result_d = special_res;
                        rd_out_d = rd_i;
                    end else if ((FAST_MUL != 0) && !is_div_in) begin
                        state_d  = ST_DONE;
                        result_d = form_result(funct3_i, prod_fast[2*XLEN-1:XLEN],
                                               prod_fast[XLEN-1:0], a_neg_in, b_neg_in);
                        rd_out_d = rd_i;
                    end else begin
                        state_d = ST_CALC;
                        cnt_d   = CNT_W'(XLEN);
                    end
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = ST_DONE;
                        result_d = form_result(op_q, step_hi, step_lo, a_neg_q, b_neg_q);
                        rd_out_d = rd_q;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: all state, datapath registers included, clears on reset so outputs read 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rd_out_q <= rd_out_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            result_q <= result_d;
        end
    end

    assign stall_o  = accept | ((state_q == ST_CALC) & ~flush_i);
    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;
    assign rd_o     = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an iterative and a single-cycle-multiply
// instance, a result/tag scoreboard, and flush/reset abort sequences.
module tb_muldiv_unit;
    import riscv_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_s = 1'b0, start_f = 1'b0, flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] a = '0, b = '0;
    logic [4:0]  rd = '0;
    logic        stall_s, busy_s, done_s, stall_f, busy_f, done_f;
    logic [31:0] res_s, res_f;
    logic [4:0]  rdo_s, rdo_f;

    int  n_pass = 0, n_total = 0, n_fail = 0, n_done_s = 0;
    sb_t sb[$];

    always #5 clk = ~clk;
    always @(negedge clk) if (done_s) n_done_s++;

    muldiv_unit #(.XLEN(32), .FAST_MUL(0)) dut_s (
        .clk(clk), .reset(reset), .start_i(start_s), .flush_i(flush), .funct3_i(funct3),
        .a_i(a), .b_i(b), .rd_i(rd), .stall_o(stall_s), .busy_o(busy_s), .done_o(done_s),
        .result_o(res_s), .rd_o(rdo_s));

    muldiv_unit #(.XLEN(32), .FAST_MUL(1)) dut_f (
        .clk(clk), .reset(reset), .start_i(start_f), .flush_i(flush), .funct3_i(funct3),
        .a_i(a), .b_i(b), .rd_i(rd), .stall_o(stall_f), .busy_o(busy_f), .done_o(done_f),
        .result_o(res_f), .rd_o(rdo_f));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, sp;
        logic [63:0] up;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (f3)
            F3_MUL:    begin up = {32'b0, x} * {32'b0, y}; model = up[31:0]; end
            F3_MULH:   begin sp = sx * sy; model = sp[63:32]; end
            F3_MULHSU: begin sp = sx * $signed({32'b0, y}); model = sp[63:32]; end
            F3_MULHU:  begin up = {32'b0, x} * {32'b0, y}; model = up[63:32]; end
            F3_DIV:    model = (y == 0) ? 32'hFFFF_FFFF :
                               (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? 32'h8000_0000 :
                               32'($signed(x) / $signed(y));
            F3_DIVU:   model = (y == 0) ? 32'hFFFF_FFFF : x / y;
            F3_REM:    model = (y == 0) ? x :
                               (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? 32'h0 :
                               32'($signed(x) % $signed(y));
            default:   model = (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int lat_of(input bit fast, input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        if (f3[2] && (y == 0)) return 1;
        if ((f3 == F3_DIV || f3 == F3_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        if (fast && !f3[2]) return 1;
        return 33;
    endfunction

    // Issues one op on the chosen instance and checks stall, latency, result and tag.
    task automatic do_op(input bit fast, input logic [2:0] f3, input logic [31:0] av,
                         input logic [31:0] bv, input logic [4:0] rdv, input logic [31:0] exp_res,
                         input string tag);
        sb_t e, got;
        int  cyc, exp_lat;
        bit  stall_ok;
        exp_lat = lat_of(fast, f3, av, bv);
        @(posedge clk); #1;
        funct3 = f3; a = av; b = bv; rd = rdv;
        if (fast) start_f = 1'b1; else start_s = 1'b1;
        #1;
        check({tag, " stall@accept"}, fast ? stall_f : stall_s, 1);
        e.res = exp_res; e.rd = rdv;
        sb.push_back(e);
        @(posedge clk); #1;
        start_s = 1'b0; start_f = 1'b0;
        a = $urandom; b = $urandom;
        cyc = 1; stall_ok = 1'b1;
        while (!(fast ? done_f : done_s) && cyc < 200) begin
            if (!(fast ? stall_f : stall_s)) stall_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        got = sb.pop_front();
        check({tag, " done"}, fast ? done_f : done_s, 1);
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " stall held"}, stall_ok, 1);
        check({tag, " stall@done"}, fast ? stall_f : stall_s, 0);
        check({tag, " result"}, fast ? res_f : res_s, got.res);
        check({tag, " rd"}, fast ? rdo_f : rdo_s, got.rd);
        @(posedge clk); #1;
        check({tag, " done pulse"}, fast ? done_f : done_s, 0);
        check({tag, " result hold"}, fast ? res_f : res_s, got.res);
    endtask

    initial begin
        int done_before;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;

        repeat (2) @(posedge clk);
        #1;
        check("reset stall", stall_s, 0);
        check("reset busy", busy_s, 0);
        check("reset done", done_s, 0);
        check("reset result", res_s, 0);
        check("reset rd", rdo_s, 0);
        check("reset fast busy", busy_f, 0);
        reset = 1'b0;

        do_op(0, F3_DIVU,  32'd100,       32'd7,         5'd5,  32'd14,        "divu");
        do_op(0, F3_REM,   32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, "rem neg");
        do_op(0, F3_DIV,   32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, "div neg");
        do_op(0, F3_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000, "div ovf");
        do_op(0, F3_DIVU,  32'd55,        32'd0,         5'd9,  32'hFFFF_FFFF, "divu by0");
        do_op(0, F3_REMU,  32'd9,         32'd0,         5'd10, 32'd9,         "remu by0");
        do_op(0, F3_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'h0,         "mulh");
        do_op(0, F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFE, "mulhu");
        do_op(0, F3_MUL,   32'd6,         32'd7,         5'd13, 32'd42,        "mul");
        do_op(0, F3_MULHSU, 32'h8000_0001, 32'hC000_0000, 5'd14,
              model(F3_MULHSU, 32'h8000_0001, 32'hC000_0000), "mulhsu");
        do_op(1, F3_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'h0,         "fast mulh");
        do_op(1, F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_FFFE, "fast mulhu");
        do_op(1, F3_MUL,   32'd6,         32'd7,         5'd17, 32'd42,        "fast mul");
        do_op(1, F3_DIVU,  32'd100,       32'd7,         5'd18, 32'd14,        "fast divu");
        for (int i = 0; i < 4; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra = $urandom; rb = $urandom;
            do_op(i[0], rf3, ra, rb, 5'(20 + i), model(rf3, ra, rb), "random");
        end

        // flush in IDLE blocks acceptance
        @(posedge clk); #1;
        funct3 = F3_DIVU; a = 32'd1000; b = 32'd3; start_s = 1'b1; flush = 1'b1;
        #1;
        check("idle flush stall", stall_s, 0);
        @(posedge clk); #1;
        start_s = 1'b0; flush = 1'b0;
        check("idle flush busy", busy_s, 0);

        // flush in CALC at T+10, new MUL at T+12
        done_before = n_done_s;
        @(posedge clk); #1;
        funct3 = F3_DIVU; a = 32'd1000; b = 32'd3; rd = 5'd3; start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("calc busy T+9", busy_s, 1);
        @(posedge clk); #1;
        flush = 1'b1;
        #1;
        check("calc flush stall", stall_s, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy T+11", busy_s, 0);
        do_op(0, F3_MUL, 32'd123, 32'd456, 5'd4, 32'd56088, "mul after flush");
        check("flush done count", n_done_s - done_before, 1);

        // reset at T+5 of a DIV
        done_before = n_done_s;
        @(posedge clk); #1;
        funct3 = F3_DIV; a = 32'd1000; b = 32'd3; rd = 5'd2; start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midop reset stall", stall_s, 0);
        check("midop reset busy", busy_s, 0);
        check("midop reset done", done_s, 0);
        check("midop reset result", res_s, 0);
        check("midop reset rd", rdo_s, 0);
        repeat (40) @(posedge clk);
        #1;
        check("midop reset no done", n_done_s - done_before, 0);
        check("midop reset idle", busy_s, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
